// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential shift-and-add-3 binary to packed BCD converter, one shift per cycle
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous active-low reset
//   enable    1 = advance, 0 = freeze every register
//   start     begin a conversion of binary (sampled only while idle)
//   binary    BIN_W-bit value captured on an accepted start
//   busy      high while shifting
//   done      one-cycle pulse when bcd/overflow are updated
//   overflow  last value exceeded 10^DIGITS-1
//   bcd       packed BCD result, digit 0 (ones) in bcd[3:0]
module bin_to_bcd_seq #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  start,
  input  logic [BIN_W-1:0]      binary,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [4*DIGITS-1:0]   bcd
);
  localparam int BW = 4*DIGITS;
  localparam int CW = $clog2(BIN_W+1);
  localparam logic [CW-1:0] LAST = CW'(BIN_W-1);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state;
  logic [BIN_W-1:0] sreg;
  logic [BW-1:0] scratch, adj, nxt;
  logic ovf_acc, ovf_nxt;
  logic [CW-1:0] count;
  for (genvar i = 0; i < DIGITS; i++) begin : g_adj
    assign adj[4*i +: 4] = (scratch[4*i +: 4] >= 4'd5) ? scratch[4*i +: 4] + 4'd3 : scratch[4*i +: 4];
  end
  // A set bit leaving the top nibble means the value needs more digits than we have.
  assign nxt     = {adj[BW-2:0], sreg[BIN_W-1]};
  assign ovf_nxt = ovf_acc | adj[BW-1];
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state    <= IDLE;
      sreg     <= '0;
      scratch  <= '0;
      ovf_acc  <= 1'b0;
      count    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
      bcd      <= '0;
    end else if (enable) begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          state   <= SHIFT;
          busy    <= 1'b1;
          sreg    <= binary;
          scratch <= '0;
          ovf_acc <= 1'b0;
          count   <= '0;
        end
      end else begin
        sreg    <= sreg << 1;
        scratch <= nxt;
        ovf_acc <= ovf_nxt;
        count   <= count + 1'b1;
        if (count == LAST) begin
          state    <= IDLE;
          busy     <= 1'b0;
          done     <= 1'b1;
          overflow <= ovf_nxt;
          bcd      <= ovf_nxt ? {DIGITS{4'h9}} : nxt;
        end
      end
    end
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: scoreboard bench for bin_to_bcd_seq (8-bit and 10-bit instances)
module tb_bin_to_bcd_seq;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset, enable, start;
  logic [7:0] binary;
  logic busy, done, overflow;
  logic [11:0] bcd;
  logic reset_b, enable_b, start_b;
  logic [9:0] binary_b;
  logic busy_b, done_b, overflow_b;
  logic [11:0] bcd_b;
  int checks = 0, failures = 0;
  int done_a = 0, done_bc = 0;
  logic [12:0] exp_a[$];
  logic [12:0] exp_b[$];
  bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) dut_a (
    .clk(clk), .reset(reset), .enable(enable), .start(start), .binary(binary),
    .busy(busy), .done(done), .overflow(overflow), .bcd(bcd));
  bin_to_bcd_seq #(.BIN_W(10), .DIGITS(3)) dut_b (
    .clk(clk), .reset(reset_b), .enable(enable_b), .start(start_b), .binary(binary_b),
    .busy(busy_b), .done(done_b), .overflow(overflow_b), .bcd(bcd_b));
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask
  always @(negedge clk) if (done) begin
    done_a++;
    if (exp_a.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL a_unexpected_done actual={%0b,%0h} required=no_done", overflow, bcd);
    end else chk("a_result", {19'd0, overflow, bcd}, {19'd0, exp_a.pop_front()});
  end
  always @(negedge clk) if (done_b) begin
    done_bc++;
    if (exp_b.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL b_unexpected_done actual={%0b,%0h} required=no_done", overflow_b, bcd_b);
    end else chk("b_result", {19'd0, overflow_b, bcd_b}, {19'd0, exp_b.pop_front()});
  end
  task automatic conv_a(input logic [7:0] v, input logic [12:0] e, input string nm);
    int n;
    @(negedge clk);
    binary = v;
    start = 1'b1;
    exp_a.push_back(e);
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy && n < 30) begin n++; @(negedge clk); end
    chk({nm, "_busy_cycles"}, n, 8);
    chk({nm, "_done"}, done, 1);
    @(negedge clk);
    chk({nm, "_done_pulse"}, done, 0);
  endtask
  task automatic conv_b(input logic [9:0] v, input logic [12:0] e, input string nm);
    int n;
    @(negedge clk);
    binary_b = v;
    start_b = 1'b1;
    exp_b.push_back(e);
    @(negedge clk);
    start_b = 1'b0;
    n = 0;
    while (busy_b && n < 30) begin n++; @(negedge clk); end
    chk({nm, "_busy_cycles"}, n, 10);
    chk({nm, "_done"}, done_b, 1);
    @(negedge clk);
    chk({nm, "_done_pulse"}, done_b, 0);
  endtask
  initial begin
    int n, k, d0;
    int t[3];
    reset = 1'b0; enable = 1'b1; start = 1'b1; binary = 8'd200;
    reset_b = 1'b0; enable_b = 1'b1; start_b = 1'b0; binary_b = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_bcd", bcd, 0);
    start = 1'b0; reset = 1'b1; reset_b = 1'b1;
    @(negedge clk);
    chk("rst_no_conv", busy, 0);
    conv_a(8'd255, 13'h0255, "c255");
    conv_a(8'd0,   13'h0000, "c0");
    conv_a(8'd9,   13'h0009, "c9");
    conv_a(8'd100, 13'h0100, "c100");
    conv_a(8'd63,  13'h0063, "c63");
    // start pulsed while busy must be ignored
    @(negedge clk);
    binary = 8'd255; start = 1'b1; exp_a.push_back(13'h0255);
    @(negedge clk);
    start = 1'b0; binary = 8'd0;
    repeat (2) @(negedge clk);
    binary = 8'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 3;
    while (busy && n < 30) begin n++; @(negedge clk); end
    chk("ign_busy_cycles", n, 8);
    chk("ign_done", done, 1);
    @(negedge clk);
    chk("ign_no_restart", busy, 0);
    // start held high: back-to-back conversions every BIN_W+1 cycles
    binary = 8'd42; start = 1'b1;
    repeat (3) exp_a.push_back(13'h0042);
    k = 0;
    for (int c = 0; c < 40 && k < 3; c++) begin
      @(negedge clk);
      if (done) begin t[k] = c; k++; end
    end
    start = 1'b0;
    chk("b2b_count", k, 3);
    chk("b2b_first", t[0], 8);
    chk("b2b_period1", t[1] - t[0], 9);
    chk("b2b_period2", t[2] - t[1], 9);
    // reset mid-conversion discards the result
    @(negedge clk);
    binary = 8'd200; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_bcd", bcd, 0);
    chk("midrst_done", done, 0);
    d0 = done_a;
    @(negedge clk);
    reset = 1'b1;
    repeat (12) @(negedge clk);
    chk("midrst_no_done", done_a - d0, 0);
    chk("midrst_idle", busy, 0);
    // enable low mid-conversion stretches it by the frozen cycles
    @(negedge clk);
    binary = 8'd100; start = 1'b1; exp_a.push_back(13'h0100);
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      n++;
      if (n == 3) enable = 1'b0;
      if (n == 8) begin chk("frz_busy_held", busy, 1); chk("frz_no_done", done, 0); enable = 1'b1; end
      @(negedge clk);
    end
    chk("frz_busy_cycles", n, 13);
    chk("frz_done", done, 1);
    @(negedge clk);
    chk("frz_bcd_held", bcd, 12'h100);
    // 10-bit instance
    conv_b(10'd999,  13'h0999, "b999");
    conv_b(10'd1000, 13'h1999, "b1000");
    conv_b(10'd509,  13'h0509, "b509");
    conv_b(10'd1023, 13'h1999, "b1023");
    conv_b(10'd10,   13'h0010, "b10");
    repeat (3) @(negedge clk);
    chk("a_queue_empty", exp_a.size(), 0);
    chk("b_queue_empty", exp_b.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
